// File: rtl/bcast_fanout_buf.sv
// Input FIFO whose head word is broadcast to NOUT consumers; the head retires once every consumer has taken it.
// Optional BCAST_FANOUT_BUF_STATS_EN adds retired_cnt / stall_cnt statistics outputs.
module bcast_fanout_buf #(
  parameter int WIDTH = 8,
  parameter int NOUT  = 4,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic [NOUT-1:0]          out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic [NOUT-1:0]          out_ready,
  output logic [$clog2(DEPTH):0]   level
`ifdef BCAST_FANOUT_BUF_STATS_EN
  ,
  output logic [15:0]              retired_cnt,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q, rd_next;
  logic [LW-1:0]    level_q, level_d;
  logic [NOUT-1:0]  done_q, done_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             active_q;
  logic             wr_en, retire, not_empty;

  // active_q keeps in_ready low through reset and releases it one cycle after.
  assign not_empty = (level_q != '0);
  assign in_ready  = active_q && (level_q < LW'(DEPTH));
  assign wr_en     = in_valid && in_ready;
  assign retire    = not_empty && (&(done_q | out_ready));
  assign rd_next   = rd_ptr_q + AW'(1);
  assign out_data  = head_q;
  assign level     = level_q;

  for (genvar gi = 0; gi < NOUT; gi++) begin : g_valid
    assign out_valid[gi] = not_empty && !done_q[gi];
  end

  always_comb begin
    done_d  = done_q | (out_valid & out_ready);
    level_d = level_q;
    head_d  = head_q;
    if (retire) begin
      done_d = '0;
    end
    case ({wr_en, retire})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // head_q is a registered copy of the head slot, refreshed when the head changes.
    if (retire) begin
      if (level_q > LW'(1)) begin
        head_d = mem_q[rd_next];
      end else if (wr_en) begin
        head_d = in_data;
      end
    end else if (wr_en && !not_empty) begin
      head_d = in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      done_q   <= '0;
    end else begin
      active_q <= 1'b1;
      level_q  <= level_d;
      done_q   <= done_d;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (retire) begin
        rd_ptr_q <= rd_next;
      end
    end
  end

  always_ff @(posedge clk) begin
    head_q <= head_d;
    if (wr_en) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

`ifdef BCAST_FANOUT_BUF_STATS_EN
  logic [15:0] retired_cnt_q, stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      retired_cnt_q <= '0;
      stall_cnt_q   <= '0;
    end else begin
      if (retire) begin
        retired_cnt_q <= retired_cnt_q + 16'd1;
      end
      if (not_empty && !retire) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end
    end
  end

  assign retired_cnt = retired_cnt_q;
  assign stall_cnt   = stall_cnt_q;
`endif

endmodule

// File: tb/tb_bcast_fanout_buf.sv
// Scoreboard bench for bcast_fanout_buf: per-consumer expected queues filled on accept, drained by a monitor.
module tb_bcast_fanout_buf;
  localparam int WIDTH = 8;
  localparam int NOUT  = 4;
  localparam int DEPTH = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic [NOUT-1:0]  out_valid;
  logic [WIDTH-1:0] out_data;
  logic [NOUT-1:0]  out_ready;
  logic [1:0]       level;
`ifdef BCAST_FANOUT_BUF_STATS_EN
  logic [15:0]      retired_cnt, stall_cnt;
  logic [15:0]      ret0, stall0;
`endif

  bcast_fanout_buf #(.WIDTH(WIDTH), .NOUT(NOUT), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level)
`ifdef BCAST_FANOUT_BUF_STATS_EN
    ,
    .retired_cnt (retired_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  bit mon_en   = 1'b0;
  logic [WIDTH-1:0] exp_q [NOUT][$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
    end else begin
      pass_cnt++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word, wait (bounded) for in_ready, record it as expected for every consumer.
  task automatic accept(input logic [WIDTH-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    for (int i = 0; i < NOUT; i++) exp_q[i].push_back(d);
    $display("accept word 0x%02h", d);
    tick();
  endtask

  // Monitor: every consumer transfer must match the oldest word that consumer has not yet seen.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < NOUT; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            check("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
          end else begin
            check("out_data", 32'(out_data), 32'(exp_q[i].pop_front()));
            $display("consumer %0d took 0x%02h", i, out_data);
          end
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = '0;
    tick();
    tick();
    check("rst_level", 32'(level), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    check("in_ready_before_release_edge", 32'(in_ready), 32'd0);
    tick();
    check("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Single word, everyone ready: visible next cycle, retires on that edge.
    out_ready = 4'hF;
    accept(8'hA5);
    in_valid = 1'b0;
    check("single_valid", 32'(out_valid), 32'hF);
    check("single_data", 32'(out_data), 32'hA5);
    check("single_level", 32'(level), 32'd1);
    tick();
    check("single_level_after", 32'(level), 32'd0);
    check("single_valid_after", 32'(out_valid), 32'd0);

    // Staggered consumers; already-done readies must be ignored.
    out_ready = 4'h0;
`ifdef BCAST_FANOUT_BUF_STATS_EN
    ret0   = retired_cnt;
    stall0 = stall_cnt;
`endif
    accept(8'h3C);
    in_valid = 1'b0;
    check("stag_valid0", 32'(out_valid), 32'hF);
    out_ready = 4'h1;
    tick();
    check("stag_valid1", 32'(out_valid), 32'hE);
    check("stag_data1", 32'(out_data), 32'h3C);
    out_ready = 4'h3;
    tick();
    check("stag_valid2", 32'(out_valid), 32'hC);
    out_ready = 4'h7;
    tick();
    check("stag_valid3", 32'(out_valid), 32'h8);
    check("stag_data3", 32'(out_data), 32'h3C);
    out_ready = 4'hF;
    tick();
    check("stag_level", 32'(level), 32'd0);
    check("stag_valid4", 32'(out_valid), 32'd0);
`ifdef BCAST_FANOUT_BUF_STATS_EN
    check("stats_retired", 32'(retired_cnt - ret0), 32'd1);
    check("stats_stall", 32'(stall_cnt - stall0), 32'd3);
`endif

    // Fill to DEPTH; the third word must wait, even across the retire edge.
    out_ready = 4'h0;
    accept(8'h11);
    accept(8'h22);
    in_data = 8'h33;
    check("full_level", 32'(level), 32'd2);
    check("full_in_ready", 32'(in_ready), 32'd0);
    tick();
    tick();
    check("full_level_hold", 32'(level), 32'd2);
    check("full_head", 32'(out_data), 32'h11);
    out_ready = 4'hF;
    tick();
    check("full_retire_no_write", 32'(level), 32'd1);
    check("full_next_head", 32'(out_data), 32'h22);
    accept(8'h33);
    in_valid = 1'b0;
    check("wr_and_retire_level", 32'(level), 32'd1);
    check("wr_and_retire_head", 32'(out_data), 32'h33);
    tick();
    check("fill_drained", 32'(level), 32'd0);

    // Back-to-back stream with pointer wrap.
    out_ready = 4'hF;
    for (int k = 0; k < 32; k++) accept(WIDTH'(k));
    in_valid = 1'b0;
    tick();
    check("stream_level", 32'(level), 32'd0);

    // Reset with two words buffered and partial done mask.
    out_ready = 4'h0;
    accept(8'h44);
    accept(8'h55);
    in_valid = 1'b0;
    check("pre_rst_level", 32'(level), 32'd2);
    out_ready = 4'h5;
    tick();
    check("pre_rst_valid", 32'(out_valid), 32'hA);
    rst_n     = 1'b0;
    out_ready = 4'h0;
    tick();
    for (int i = 0; i < NOUT; i++) exp_q[i].delete();
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_valid", 32'(out_valid), 32'd0);
    out_ready = 4'hF;
    accept(8'h66);
    in_valid = 1'b0;
    check("post_rst_word_valid", 32'(out_valid), 32'hF);
    check("post_rst_word_data", 32'(out_data), 32'h66);
    tick();
    check("post_rst_level", 32'(level), 32'd0);

    tick();
    tick();
    for (int i = 0; i < NOUT; i++) check("queue_empty", 32'(exp_q[i].size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running, required finished");
    $fatal(1, "timeout");
  end
endmodule
